act_feeder: RTL and testbench
=============================

// Module: act_feeder
// PURPOSE
//  Activation source feeding sblk_row: answers sblk_row's act_data_in_req with a burst of
//  packed activation pairs on act_data_in/act_data_in_vld. Holds activations in an internal
//  buffer loaded by an upstream write port. One instruction (n_tn, n_tp, base) = one burst of
//  n_tn*n_tp beats, cnt_n outer / cnt_p inner, read from consecutive buffer addresses.
// PARAMETERS
//  WID_ACT      16  width of one activation; each beat carries two (2*WID_ACT bits)
//  WID_ACTADDR  6   buffer address width; depth = 2**WID_ACTADDR words of 2*WID_ACT bits
//  WID_INST_TN  3   width of n_tn field
//  WID_INST_TP  3   width of n_tp field
//  WID_INST     WID_INST_TN+WID_INST_TP+WID_ACTADDR  instruction width {base, n_tp, n_tn}
// PORTS
//  clk_l            in   1              clock
//  rst_n            in   1              async reset, active low
//  inst_data        in   WID_INST       {base[WID_ACTADDR], n_tp, n_tn}, n_tn in LSBs
//  inst_en          in   1              instruction strobe, 1 cycle
//  act_wr_en        in   1              buffer write enable
//  act_wr_addr      in   WID_ACTADDR    buffer write address
//  act_wr_data      in   2*WID_ACT      buffer write data {act1, act0}
//  act_data_in_req  in   1              request from sblk_row (level)
//  act_data_in_vld  out  1              beat valid
//  act_data_in      out  2*WID_ACT      beat data; act0 in [WID_ACT-1:0]
//  busy             out  1              instruction held, burst not finished
//  done             out  1              1-cycle pulse at burst completion
//  inst_drop        out  1              1-cycle pulse: inst_en ignored while busy
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, counters 0, act_data_in_vld=0, act_data_in=0, busy=0,
//   done=0, inst_drop=0. Buffer contents not reset. Reset mid-burst aborts it; no beats after.
//  FSM: IDLE -> WAIT_REQ -> STREAM -> DRAIN -> IDLE.
//   IDLE: inst_en=1 latches n_tn, n_tp, base; busy=1 next cycle; -> WAIT_REQ. If n_tn==0 or
//    n_tp==0: no beats, done pulses next cycle, stays IDLE, busy stays 0.
//   WAIT_REQ: req sampled each posedge; req=1 -> STREAM. req sampled only here.
//   STREAM: one buffer read per cycle, addr = base + beat (beat 0..N-1, N=n_tn*n_tp, computed
//    width WID_INST_TN+WID_INST_TP), address wraps mod 2**WID_ACTADDR. After read N-1 -> DRAIN.
//   DRAIN: last beat's vld cycle; done=1 this cycle; busy=0 and -> IDLE next cycle.
//  Latency: req seen high at edge k -> first vld in cycle after edge k+2 (read addr reg +
//   1-cycle buffer read + output reg); N beats back-to-back, no gaps, no backpressure.
//  Output: act_data_in registered; forced 0 whenever vld=0.
//  inst_en while busy: ignored, inst_drop=1 next cycle, latched fields unchanged.
//  inst_en in DRAIN cycle also dropped (busy still 1).
//  Write port always active. Same-address write and read in one cycle: read returns old data.
//  req deasserting mid-burst does not stop it; req still high after done waits for next inst.
// TESTING
//  T1 load addr 0..5 = {16'h1000+i,16'h0000+i}; inst n_tn=3 n_tp=2 base=0; req=1 -> 6 beats,
//   data addr 0..5 in order, contiguous vld, first vld 2 cycles after req edge, done with beat 6.
//  T2 base=62, n_tn=2 n_tp=2, WID_ACTADDR=6 -> beats from addr 62,63,0,1 (wrap).
//  T3 inst n_tn=0 -> no vld, done pulses 1 cycle after inst_en, busy stays 0.
//  T4 second inst_en during STREAM -> inst_drop pulse, burst unchanged; inst after done runs.
//  T5 rst_n=0 on beat 3 of 6 -> vld/data/busy 0 immediately; new inst after reset streams OK.
//  T6 write addr 4 while beat 4 reads addr 4 -> old data; next burst sees new data.

Source files
------------

// File: rtl/act_feeder_if.sv
// Bundle between act_feeder and its neighbours: instruction strobe, buffer write port,
// sblk_row request and the activation beat stream with status pulses.
interface act_feeder_if #(
    parameter int WID_ACT     = 16,
    parameter int WID_ACTADDR = 6,
    parameter int WID_INST    = 12
);
    logic [WID_INST-1:0]    inst_data;
    logic                   inst_en;
    logic                   act_wr_en;
    logic [WID_ACTADDR-1:0] act_wr_addr;
    logic [2*WID_ACT-1:0]   act_wr_data;
    logic                   act_data_in_req;
    logic                   act_data_in_vld;
    logic [2*WID_ACT-1:0]   act_data_in;
    logic                   busy;
    logic                   done;
    logic                   inst_drop;

    modport slave (
        input  inst_data, inst_en, act_wr_en, act_wr_addr, act_wr_data, act_data_in_req,
        output act_data_in_vld, act_data_in, busy, done, inst_drop
    );

    modport master (
        output inst_data, inst_en, act_wr_en, act_wr_addr, act_wr_data, act_data_in_req,
        input  act_data_in_vld, act_data_in, busy, done, inst_drop
    );
endinterface

// File: rtl/act_feeder.sv
// Activation source for sblk_row: buffers packed activation pairs and, per instruction,
// streams n_tn*n_tp consecutive buffer words once sblk_row raises its request.
module act_feeder #(
    parameter int WID_ACT     = 16,
    parameter int WID_ACTADDR = 6,
    parameter int WID_INST_TN = 3,
    parameter int WID_INST_TP = 3,
    parameter int WID_INST    = WID_INST_TN + WID_INST_TP + WID_ACTADDR
) (
    input  logic         clk_l,
    input  logic         rst_n,
    act_feeder_if.slave  bus
);
    localparam int WID_N   = WID_INST_TN + WID_INST_TP;
    localparam int WID_SUM = (WID_N > WID_ACTADDR) ? WID_N : WID_ACTADDR;
    localparam int DEPTH   = 2 ** WID_ACTADDR;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_REQ, S_STREAM, S_DRAIN} state_t;

    state_t state_reg, state_next;

    logic [WID_ACTADDR-1:0] base_reg;
    logic [WID_N-1:0]       n_total_reg;
    logic [WID_N-1:0]       beat_reg;
    logic                   rd_vld_reg;
    logic                   rd_last_reg;
    logic [2*WID_ACT-1:0]   rd_data_reg;
    logic                   vld_reg;
    logic [2*WID_ACT-1:0]   data_reg;
    logic                   done_reg;
    logic                   drop_reg;

    logic [2*WID_ACT-1:0]   mem [DEPTH];

    logic [WID_INST_TN-1:0] n_tn_in;
    logic [WID_INST_TP-1:0] n_tp_in;
    logic [WID_ACTADDR-1:0] base_in;
    logic                   inst_zero;
    logic                   inst_accept;
    logic                   beat_last;
    logic [WID_SUM-1:0]     addr_sum;
    logic [WID_ACTADDR-1:0] rd_addr;

    assign n_tn_in     = bus.inst_data[WID_INST_TN-1:0];
    assign n_tp_in     = bus.inst_data[WID_INST_TN +: WID_INST_TP];
    assign base_in     = bus.inst_data[WID_N +: WID_ACTADDR];
    assign inst_zero   = (n_tn_in == '0) || (n_tp_in == '0);
    assign inst_accept = bus.inst_en && (state_reg == S_IDLE);
    assign beat_last   = (beat_reg == n_total_reg - WID_N'(1));

    // Address wraps naturally by truncating the sum to the buffer address width.
    assign addr_sum = WID_SUM'(base_reg) + WID_SUM'(beat_reg);
    assign rd_addr  = addr_sum[WID_ACTADDR-1:0];

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // DRAIN covers the pipeline flush and ends on the cycle the last beat is shown.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:     if (bus.inst_en && !inst_zero) state_next = S_WAIT_REQ;
            S_WAIT_REQ: if (bus.act_data_in_req)       state_next = S_STREAM;
            S_STREAM:   if (beat_last)                 state_next = S_DRAIN;
            S_DRAIN:    if (done_reg)                  state_next = S_IDLE;
            default:                                   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            base_reg    <= '0;
            n_total_reg <= '0;
            beat_reg    <= '0;
            rd_vld_reg  <= 1'b0;
            rd_last_reg <= 1'b0;
            vld_reg     <= 1'b0;
            data_reg    <= '0;
            done_reg    <= 1'b0;
            drop_reg    <= 1'b0;
        end else begin
            if (inst_accept && !inst_zero) begin
                base_reg    <= base_in;
                n_total_reg <= WID_N'(n_tn_in) * WID_N'(n_tp_in);
                beat_reg    <= '0;
            end else if (state_reg == S_STREAM) begin
                beat_reg <= beat_reg + WID_N'(1);
            end
            rd_vld_reg  <= (state_reg == S_STREAM);
            rd_last_reg <= (state_reg == S_STREAM) && beat_last;
            vld_reg     <= rd_vld_reg;
            data_reg    <= rd_vld_reg ? rd_data_reg : '0;
            done_reg    <= rd_last_reg || (inst_accept && inst_zero);
            drop_reg    <= bus.inst_en && (state_reg != S_IDLE);
        end
    end

    // Buffer: write port always live; registered read returns pre-write data on collision.
    always_ff @(posedge clk_l) begin
        if (bus.act_wr_en) begin
            mem[bus.act_wr_addr] <= bus.act_wr_data;
        end
        if (state_reg == S_STREAM) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign bus.act_data_in_vld = vld_reg;
    assign bus.act_data_in     = data_reg;
    assign bus.busy            = (state_reg != S_IDLE);
    assign bus.done            = done_reg;
    assign bus.inst_drop       = drop_reg;
endmodule

// File: tb/tb_act_feeder.sv
// Scoreboarded bench for act_feeder: stimulus pushes expected beats/pulses, a negedge
// monitor pops and compares whatever the DUT presents.
module tb_act_feeder;
    localparam int WA    = 16;
    localparam int WADDR = 6;
    localparam int WTN   = 3;
    localparam int WTP   = 3;
    localparam int WI    = WTN + WTP + WADDR;
    localparam int DEPTH = 64;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } beat_t;

    logic clk_l = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk_l = ~clk_l;

    act_feeder_if #(.WID_ACT(WA), .WID_ACTADDR(WADDR), .WID_INST(WI)) bus ();

    act_feeder #(
        .WID_ACT(WA), .WID_ACTADDR(WADDR), .WID_INST_TN(WTN), .WID_INST_TP(WTP)
    ) dut (
        .clk_l(clk_l),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] ref_mem [DEPTH];
    beat_t       sb_q [$];
    bit          exp_done [int];
    bit          exp_drop [int];
    beat_t       mon_e;

    always @(posedge clk_l) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk_l) begin
        if (rst_n) begin
            if (bus.act_data_in_vld) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_beat", 64'(bus.act_data_in), 64'hx);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("beat_data", 64'(bus.act_data_in), 64'(mon_e.data));
                    check("beat_cycle", 64'(cyc), 64'(mon_e.cyc));
                end
            end else begin
                check("idle_data_zero", 64'(bus.act_data_in), 64'd0);
            end
            if (bus.done || exp_done.exists(cyc))
                check("done", 64'(bus.done), 64'(exp_done.exists(cyc)));
            if (bus.inst_drop || exp_drop.exists(cyc))
                check("inst_drop", 64'(bus.inst_drop), 64'(exp_drop.exists(cyc)));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic do_write(input int addr, input logic [31:0] data);
        bus.act_wr_en   = 1'b1;
        bus.act_wr_addr = WADDR'(addr);
        bus.act_wr_data = data;
        ref_mem[addr % DEPTH] = data;
        @(negedge clk_l);
        bus.act_wr_en = 1'b0;
    endtask

    task automatic run_inst(input int tn, input int tp, input int base, input int dly,
                            input bit dmid, input bit ddrain, input bit rqdrop,
                            input int wr_beat, input int rst_beat);
        int k, n, waddr;
        logic [31:0] wdata;
        n = tn * tp;
        bus.inst_data = {WADDR'(base), WTP'(tp), WTN'(tn)};
        bus.inst_en   = 1'b1;
        if (n == 0) begin
            exp_done[cyc + 1] = 1'b1;
            @(negedge clk_l);
            bus.inst_en = 1'b0;
            check("zero_busy", 64'(bus.busy), 64'd0);
            @(negedge clk_l);
            check("zero_busy_after", 64'(bus.busy), 64'd0);
            $display("inst tn=%0d tp=%0d base=%0d: empty burst", tn, tp, base);
            return;
        end
        @(negedge clk_l);
        bus.inst_en = 1'b0;
        check("busy_set", 64'(bus.busy), 64'd1);
        if (dly > 0) begin
            bus.act_data_in_req = 1'b0;
            repeat (dly) @(negedge clk_l);
        end
        bus.act_data_in_req = 1'b1;
        k = cyc + 1;
        for (int i = 0; i < n; i++)
            sb_q.push_back('{ref_mem[(base + i) % DEPTH], k + 2 + i});
        exp_done[k + 1 + n] = 1'b1;
        waddr = (base + wr_beat) % DEPTH;
        wdata = $urandom;
        while (cyc < k + n + 2) begin
            bus.inst_en   = 1'b0;
            bus.act_wr_en = 1'b0;
            if (rst_beat >= 0 && cyc == k + 2 + rst_beat) begin
                #1 rst_n = 1'b0;
                #1;
                check("rst_vld", 64'(bus.act_data_in_vld), 64'd0);
                check("rst_data", 64'(bus.act_data_in), 64'd0);
                check("rst_busy", 64'(bus.busy), 64'd0);
                check("rst_done", 64'(bus.done), 64'd0);
                sb_q.delete();
                exp_done.delete();
                exp_drop.delete();
                bus.act_data_in_req = 1'b0;
                @(negedge clk_l);
                @(negedge clk_l);
                rst_n = 1'b1;
                @(negedge clk_l);
                $display("inst tn=%0d tp=%0d base=%0d: reset at beat %0d", tn, tp, base, rst_beat);
                return;
            end
            if (dmid && cyc == k + 1) begin
                bus.inst_en   = 1'b1;
                bus.inst_data = WI'($urandom);
                exp_drop[cyc + 1] = 1'b1;
            end
            if (ddrain && cyc == k + n + 1) begin
                bus.inst_en   = 1'b1;
                bus.inst_data = WI'($urandom);
                exp_drop[cyc + 1] = 1'b1;
            end
            if (wr_beat >= 0 && cyc == k + wr_beat) begin
                bus.act_wr_en   = 1'b1;
                bus.act_wr_addr = WADDR'(waddr);
                bus.act_wr_data = wdata;
            end
            if (rqdrop && cyc == k + 1) bus.act_data_in_req = 1'b0;
            @(negedge clk_l);
        end
        bus.inst_en   = 1'b0;
        bus.act_wr_en = 1'b0;
        if (wr_beat >= 0) ref_mem[waddr] = wdata;
        check("busy_clear", 64'(bus.busy), 64'd0);
        check("all_beats_seen", 64'(sb_q.size()), 64'd0);
        $display("inst tn=%0d tp=%0d base=%0d dly=%0d drop=%0d/%0d wr=%0d: %0d beats",
                 tn, tp, base, dly, dmid, ddrain, wr_beat, n);
    endtask

    initial begin
        bus.inst_data = '0;
        bus.inst_en = 1'b0;
        bus.act_wr_en = 1'b0;
        bus.act_wr_addr = '0;
        bus.act_wr_data = '0;
        bus.act_data_in_req = 1'b0;
        repeat (3) @(negedge clk_l);
        check("reset_vld", 64'(bus.act_data_in_vld), 64'd0);
        check("reset_data", 64'(bus.act_data_in), 64'd0);
        check("reset_busy", 64'(bus.busy), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_drop", 64'(bus.inst_drop), 64'd0);
        rst_n = 1'b1;
        @(negedge clk_l);

        for (int i = 0; i < DEPTH; i++) begin
            if (i < 6) do_write(i, {16'h1000 + 16'(i), 16'h0000 + 16'(i)});
            else       do_write(i, $urandom);
        end

        run_inst(3, 2, 0, 1, 0, 0, 0, -1, -1);   // basic 6-beat burst
        run_inst(2, 2, 62, 0, 0, 0, 1, -1, -1);  // address wrap, req dropped mid-burst
        run_inst(0, 5, 3, 0, 0, 0, 0, -1, -1);   // empty bursts
        run_inst(4, 0, 9, 0, 0, 0, 0, -1, -1);
        run_inst(3, 2, 10, 2, 1, 1, 0, -1, -1);  // drops during stream and drain
        run_inst(2, 3, 20, 0, 0, 0, 0, -1, -1);
        run_inst(3, 2, 0, 0, 0, 0, 0, -1, 2);    // reset on beat 3 of 6
        run_inst(3, 2, 0, 0, 0, 0, 0, -1, -1);
        run_inst(3, 2, 0, 0, 0, 0, 0, 4, -1);    // write/read collision at addr 4
        run_inst(3, 2, 0, 0, 0, 0, 0, -1, -1);

        for (int t = 0; t < 30; t++) begin
            int tn, tp, base, nw;
            tn = $urandom_range(0, 7);
            tp = $urandom_range(0, 7);
            base = $urandom_range(0, DEPTH - 1);
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) do_write($urandom_range(0, DEPTH - 1), $urandom);
            run_inst(tn, tp, base, $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                     1'($urandom), ((tn * tp) > 0 && $urandom_range(0, 1) == 1) ?
                     $urandom_range(0, tn * tp - 1) : -1, -1);
        end

        repeat (4) @(negedge clk_l);
        check("final_queue_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
